// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit memory controller.
// Size and FSM encodings plus default widths.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } lsu_size_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2,
      DONE = 2'd3
   } lsu_state_e;

   localparam int unsigned XLEN_DEF   = 64;
   localparam int unsigned ADDR_W_DEF = 64;

   function automatic int unsigned size_bytes(lsu_size_e s);
      return 32'd1 << s;
   endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Execute-side request, memory bus and result handshakes of the LSU.
// master = LSU view, slave = surrounding pipeline / bus view.
interface lsu_mem_ctrl_if #(
   parameter int XLEN   = 64,
   parameter int ADDR_W = 64
);
   localparam int STRB_W = XLEN / 8;

   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] in_addr;
   logic              in_we;
   logic [1:0]        in_size;
   logic              in_unsigned;
   logic [XLEN-1:0]   in_wdata;

   logic              mem_req_valid;
   logic              mem_req_ready;
   logic [ADDR_W-1:0] mem_req_addr;
   logic              mem_req_we;
   logic [XLEN-1:0]   mem_req_wdata;
   logic [STRB_W-1:0] mem_req_wstrb;
   logic              mem_resp_valid;
   logic [XLEN-1:0]   mem_resp_rdata;
   logic              mem_resp_err;

   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   out_rdata;
   logic              out_fault;

   modport master (
      input  in_valid, in_addr, in_we, in_size,
      input  in_unsigned, in_wdata,
      output in_ready,
      output mem_req_valid, mem_req_addr, mem_req_we,
      output mem_req_wdata, mem_req_wstrb,
      input  mem_req_ready,
      input  mem_resp_valid, mem_resp_rdata, mem_resp_err,
      output out_valid, out_rdata, out_fault,
      input  out_ready
   );

   modport slave (
      output in_valid, in_addr, in_we, in_size,
      output in_unsigned, in_wdata,
      input  in_ready,
      input  mem_req_valid, mem_req_addr, mem_req_we,
      input  mem_req_wdata, mem_req_wstrb,
      output mem_req_ready,
      output mem_resp_valid, mem_resp_rdata, mem_resp_err,
      input  out_valid, out_rdata, out_fault,
      output out_ready
   );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane alignment: store strobes/data shift and load
// extraction with sign or zero extension.
module lsu_align
   import lsu_pkg::*;
#(
   parameter  int XLEN   = 64,
   localparam int STRB_W = XLEN / 8,
   localparam int OFF_W  = $clog2(STRB_W)
) (
   input  logic [OFF_W-1:0]  off,
   input  lsu_size_e         size,
   input  logic              uns,
   input  logic [XLEN-1:0]   st_data,
   input  logic [XLEN-1:0]   ld_beat,
   output logic [STRB_W-1:0] wstrb,
   output logic [XLEN-1:0]   wdata,
   output logic [XLEN-1:0]   ld_data
);

   logic [STRB_W-1:0] base;
   logic [XLEN-1:0]   sh;

   always_comb begin
      base = '0;
      unique case (size)
         SZ_B: base = STRB_W'(8'h01);
         SZ_H: base = STRB_W'(8'h03);
         SZ_W: base = STRB_W'(8'h0F);
         SZ_D: base = STRB_W'(8'hFF);
      endcase
   end

   // lanes shifted past the top of the beat are simply dropped
   assign wstrb = base << off;
   assign wdata = st_data << {off, 3'b000};
   assign sh    = ld_beat >> {off, 3'b000};

   always_comb begin
      ld_data = sh;
      unique case (size)
         SZ_B: ld_data = uns ? XLEN'(sh[7:0])
                             : XLEN'($signed(sh[7:0]));
         SZ_H: ld_data = uns ? XLEN'(sh[15:0])
                             : XLEN'($signed(sh[15:0]));
         SZ_W: ld_data = uns ? XLEN'(sh[31:0])
                             : XLEN'($signed(sh[31:0]));
         SZ_D: ld_data = sh;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Multicycle LSU: one transaction in flight, registered bus request.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses.
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int XLEN   = 64,
   parameter int ADDR_W = 64
) (
   input logic           clock,
   input logic           reset_n,
   lsu_mem_ctrl_if.master bus
);

   localparam int STRB_W = XLEN / 8;
   localparam int OFF_W  = $clog2(STRB_W);

   lsu_state_e        state_q;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   lsu_size_e         size_q;
   logic              uns_q;
   logic [OFF_W-1:0]  off_q;
   logic [XLEN-1:0]   wdata_q;
   logic [STRB_W-1:0] wstrb_q;
   logic [XLEN-1:0]   rdata_q;
   logic              fault_q;

   logic              idle;
   logic [OFF_W-1:0]  off_a;
   lsu_size_e         size_a;
   logic [STRB_W-1:0] al_wstrb;
   logic [XLEN-1:0]   al_wdata;
   logic [XLEN-1:0]   al_ld;
   logic              illegal;
   logic              mis;
   logic              skip;

   assign idle   = (state_q == IDLE);
   // stores align from the live request, loads from captured fields
   assign off_a  = idle ? bus.in_addr[OFF_W-1:0] : off_q;
   assign size_a = idle ? lsu_size_e'(bus.in_size) : size_q;

   lsu_align #(.XLEN(XLEN)) u_align (
      .off     (off_a),
      .size    (size_a),
      .uns     (uns_q),
      .st_data (bus.in_wdata),
      .ld_beat (bus.mem_resp_rdata),
      .wstrb   (al_wstrb),
      .wdata   (al_wdata),
      .ld_data (al_ld)
   );

   assign illegal = (XLEN == 32) && (bus.in_size == 2'd3);

`ifdef LSU_MISALIGN_TRAP_EN
   logic [OFF_W-1:0] amask;
   always_comb begin
      amask = '0;
      unique case (size_a)
         SZ_B: amask = '0;
         SZ_H: amask = OFF_W'(1);
         SZ_W: amask = OFF_W'(3);
         SZ_D: amask = OFF_W'(7);
      endcase
   end
   assign mis = |(bus.in_addr[OFF_W-1:0] & amask);
`else
   assign mis = 1'b0;
`endif

   assign skip = illegal || mis;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         size_q  <= SZ_B;
         uns_q   <= 1'b0;
         off_q   <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         rdata_q <= '0;
         fault_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: if (bus.in_valid) begin
               addr_q  <= {bus.in_addr[ADDR_W-1:OFF_W],
                           {OFF_W{1'b0}}};
               we_q    <= bus.in_we;
               size_q  <= lsu_size_e'(bus.in_size);
               uns_q   <= bus.in_unsigned;
               off_q   <= bus.in_addr[OFF_W-1:0];
               wdata_q <= al_wdata;
               wstrb_q <= bus.in_we ? al_wstrb : '0;
               rdata_q <= '0;
               fault_q <= skip;
               state_q <= skip ? DONE : REQ;
            end
            REQ: if (bus.mem_req_ready) begin
               state_q <= RESP;
            end
            RESP: if (bus.mem_resp_valid) begin
               fault_q <= bus.mem_resp_err;
               rdata_q <= (we_q || bus.mem_resp_err) ? '0 : al_ld;
               state_q <= DONE;
            end
            DONE: if (bus.out_ready) begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready      = idle;
   assign bus.mem_req_valid = (state_q == REQ);
   assign bus.mem_req_addr  = addr_q;
   assign bus.mem_req_we    = we_q;
   assign bus.mem_req_wdata = wdata_q;
   assign bus.mem_req_wstrb = wstrb_q;
   assign bus.out_valid     = (state_q == DONE);
   assign bus.out_rdata     = rdata_q;
   assign bus.out_fault     = fault_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed + randomized checks of lsu_mem_ctrl against a
// byte-level reference model (XLEN = 64).
module tb_lsu_mem_ctrl;

   logic clk;
   logic rst_n;
   int   passed;
   int   total;
   int   fails;
   int   req_cnt;

   lsu_mem_ctrl_if #(.XLEN(64), .ADDR_W(64)) bus_if ();

   lsu_mem_ctrl #(.XLEN(64), .ADDR_W(64)) dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial req_cnt = 0;
   always @(posedge clk)
      if (bus_if.mem_req_valid && bus_if.mem_req_ready)
         req_cnt <= req_cnt + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] r64();
      return {$urandom(), $urandom()};
   endfunction

   // model: gather the n addressed bytes of the beat, then extend
   function automatic logic [63:0] m_load(logic [63:0] beat,
      int off, int n, bit uns);
      logic [63:0] v;
      v = '0;
      for (int i = 0; i < n; i++)
         if (off + i < 8)
            v[8*i +: 8] = beat[8*(off+i) +: 8];
      if (!uns && n < 8 && v[8*n-1])
         v = v | (~64'd0 << (8*n));
      return v;
   endfunction

   function automatic logic [7:0] m_strb(int off, int n);
      logic [7:0] s;
      s = '0;
      for (int i = 0; i < n; i++)
         if (off + i < 8) s[off+i] = 1'b1;
      return s;
   endfunction

   task automatic txn(input logic [63:0] addr, input bit we,
      input logic [1:0] size, input bit uns,
      input logic [63:0] wdata, input logic [63:0] beat,
      input bit err, input int rq_w, input int rs_w,
      input int o_w);
      int          off;
      int          n;
      bit          trap;
      logic [63:0] e_rd;
      logic [7:0]  e_strb;
      logic [63:0] e_wd;
      logic [63:0] e_addr;
      bit          e_flt;
      int          c0;
      off    = int'(addr[2:0]);
      n      = 1 << size;
`ifdef LSU_MISALIGN_TRAP_EN
      trap   = (addr % 64'(n)) != 0;
`else
      trap   = 1'b0;
`endif
      e_addr = addr & ~64'd7;
      e_strb = we ? m_strb(off, n) : 8'h00;
      e_wd   = wdata << (8 * off);
      if (trap) begin
         e_flt = 1'b1;
         e_rd  = '0;
      end else begin
         e_flt = err;
         e_rd  = (we || err) ? 64'd0 : m_load(beat, off, n, uns);
      end
      @(negedge clk);
      chk("in_ready_idle", 64'(bus_if.in_ready), 64'd1);
      bus_if.in_valid    = 1'b1;
      bus_if.in_addr     = addr;
      bus_if.in_we       = we;
      bus_if.in_size     = size;
      bus_if.in_unsigned = uns;
      bus_if.in_wdata    = wdata;
      c0 = req_cnt;
      @(negedge clk);
      bus_if.in_valid    = 1'b0;
      bus_if.in_addr     = r64();
      bus_if.in_wdata    = r64();
      bus_if.in_size     = 2'($urandom());
      bus_if.in_we       = 1'($urandom());
      chk("in_ready_busy", 64'(bus_if.in_ready), 64'd0);
      if (!trap) begin
         for (int i = 0; i <= rq_w; i++) begin
            chk("req_valid", 64'(bus_if.mem_req_valid), 64'd1);
            chk("req_addr", bus_if.mem_req_addr, e_addr);
            chk("req_we", 64'(bus_if.mem_req_we), 64'(we));
            chk("req_wstrb", 64'(bus_if.mem_req_wstrb),
                64'(e_strb));
            if (we) chk("req_wdata", bus_if.mem_req_wdata, e_wd);
            if (i < rq_w) begin
               // spurious response while waiting must be ignored
               bus_if.mem_resp_valid = 1'b1;
               bus_if.mem_resp_rdata = r64();
               @(negedge clk);
            end
         end
         bus_if.mem_resp_valid = 1'b0;
         bus_if.mem_req_ready  = 1'b1;
         @(negedge clk);
         bus_if.mem_req_ready  = 1'b0;
         chk("req_dropped", 64'(bus_if.mem_req_valid), 64'd0);
         chk("req_count", 64'(req_cnt - c0), 64'd1);
         for (int i = 0; i < rs_w; i++) begin
            chk("wait_no_out", 64'(bus_if.out_valid), 64'd0);
            @(negedge clk);
         end
         bus_if.mem_resp_valid = 1'b1;
         bus_if.mem_resp_rdata = beat;
         bus_if.mem_resp_err   = err;
         @(negedge clk);
         bus_if.mem_resp_valid = 1'b0;
         bus_if.mem_resp_err   = 1'b0;
         bus_if.mem_resp_rdata = r64();
      end else begin
         chk("trap_no_req", 64'(bus_if.mem_req_valid), 64'd0);
         chk("trap_req_count", 64'(req_cnt - c0), 64'd0);
      end
      for (int i = 0; i <= o_w; i++) begin
         chk("out_valid", 64'(bus_if.out_valid), 64'd1);
         chk("out_rdata", bus_if.out_rdata, e_rd);
         chk("out_fault", 64'(bus_if.out_fault), 64'(e_flt));
         chk("in_ready_done", 64'(bus_if.in_ready), 64'd0);
         if (i < o_w) @(negedge clk);
      end
      bus_if.out_ready = 1'b1;
      @(negedge clk);
      bus_if.out_ready = 1'b0;
      chk("out_cleared", 64'(bus_if.out_valid), 64'd0);
      chk("back_idle", 64'(bus_if.in_ready), 64'd1);
   endtask

   initial begin
      passed = 0;
      total  = 0;
      fails  = 0;
      rst_n  = 1'b0;
      bus_if.in_valid       = 1'b0;
      bus_if.in_addr        = '0;
      bus_if.in_we          = 1'b0;
      bus_if.in_size        = 2'd0;
      bus_if.in_unsigned    = 1'b0;
      bus_if.in_wdata       = '0;
      bus_if.mem_req_ready  = 1'b0;
      bus_if.mem_resp_valid = 1'b0;
      bus_if.mem_resp_rdata = '0;
      bus_if.mem_resp_err   = 1'b0;
      bus_if.out_ready      = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 64'(bus_if.in_ready), 64'd1);
      chk("rst_req_valid", 64'(bus_if.mem_req_valid), 64'd0);
      chk("rst_req_addr", bus_if.mem_req_addr, 64'd0);
      chk("rst_req_we", 64'(bus_if.mem_req_we), 64'd0);
      chk("rst_req_wdata", bus_if.mem_req_wdata, 64'd0);
      chk("rst_req_wstrb", 64'(bus_if.mem_req_wstrb), 64'd0);
      chk("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
      chk("rst_out_rdata", bus_if.out_rdata, 64'd0);
      chk("rst_out_fault", 64'(bus_if.out_fault), 64'd0);
      rst_n = 1'b1;

      // word store into upper half of the beat
      txn(64'h8000_0004, 1, 2'd2, 0, 64'h1122_3344,
          r64(), 0, 0, 0, 0);
      // signed and unsigned byte loads
      txn(64'h8000_0003, 0, 2'd0, 0, r64(),
          64'h0000_0000_8000_0000, 0, 0, 0, 0);
      txn(64'h8000_0003, 0, 2'd0, 1, r64(),
          64'h0000_0000_8000_0000, 0, 0, 0, 0);
      // backpressure on both sides
      txn(64'h8000_0010, 1, 2'd1, 0, r64(),
          r64(), 0, 5, 3, 2);
      // bus error on a load
      txn(64'h8000_0020, 0, 2'd2, 0, r64(),
          r64(), 1, 1, 1, 0);
      // misaligned halfword and full doubleword
      txn(64'h8000_0101, 0, 2'd1, 0, r64(),
          64'h0000_0000_00F0_0000, 0, 0, 0, 0);
      txn(64'h8000_0108, 1, 2'd3, 0, r64(),
          r64(), 0, 0, 0, 0);
      txn(64'h8000_0107, 0, 2'd2, 0, r64(),
          r64(), 0, 0, 0, 0);

      // reset while waiting for the response
      @(negedge clk);
      bus_if.in_valid = 1'b1;
      bus_if.in_addr  = 64'h8000_0200;
      bus_if.in_we    = 1'b0;
      bus_if.in_size  = 2'd3;
      @(negedge clk);
      bus_if.in_valid      = 1'b0;
      bus_if.mem_req_ready = 1'b1;
      @(negedge clk);
      bus_if.mem_req_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req", 64'(bus_if.mem_req_valid), 64'd0);
      chk("mid_rst_ready", 64'(bus_if.in_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      bus_if.mem_resp_valid = 1'b1;
      bus_if.mem_resp_rdata = r64();
      chk("post_rst_ready", 64'(bus_if.in_ready), 64'd1);
      @(negedge clk);
      bus_if.mem_resp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("post_rst_no_out", 64'(bus_if.out_valid), 64'd0);
         chk("post_rst_idle", 64'(bus_if.in_ready), 64'd1);
         @(negedge clk);
      end

      for (int k = 0; k < 40; k++) begin
         txn(r64(), 1'($urandom()), 2'($urandom()),
             1'($urandom()), r64(), r64(),
             ($urandom_range(0, 7) == 0),
             $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 2));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Multicycle load/store unit between the execute stage and a single-port data-memory bus.
- Replaces the combinational DPI-coupled LSU. Uses a valid/ready request, a registered bus transaction, byte-lane alignment/strobe generation, load sign/zero extension, and fault reporting.
- Parametrised in data and address width.
- One transaction in flight. The request is accepted, issued on the bus, and the response is returned through a held output handshake.

Parameters:
- XLEN, 64, data width; legal values are 32 or 64.
- ADDR_W, 64, address width.
- STRB_W, XLEN/8, derived; byte strobes per beat.
- OFF_W, log2(STRB_W), derived; byte-offset bits of the address.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid from execute.
- in_ready  out  1  LSU can accept a request.
- in_addr  in  ADDR_W  byte address.
- in_we  in  1  1 = store, 0 = load.
- in_size  in  2  0 = B, 1 = H, 2 = W, 3 = D.
- in_unsigned  in  1  load zero-extends when 1; ignored for stores.
- in_wdata  in  XLEN  store data, right-justified.
- mem_req_valid  out  1  bus request valid.
- mem_req_ready  in  1  bus accepts request.
- mem_req_addr  out  ADDR_W  in_addr with low OFF_W bits cleared.
- mem_req_we  out  1  store flag.
- mem_req_wdata  out  XLEN  lane-shifted store data.
- mem_req_wstrb  out  STRB_W  byte enables; 0 for loads.
- mem_resp_valid  in  1  bus response valid (single cycle).
- mem_resp_rdata  in  XLEN  raw read beat.
- mem_resp_err  in  1  bus error.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_rdata  out  XLEN  extended load data; 0 for stores and faults.
- out_fault  out  1  access faulted.

Behaviour:
- FSM states: IDLE, REQ, RESP, DONE.
- Reset (asynchronous, reset_n = 0):
  - State goes to IDLE and all registers clear.
  - Every output is 0 except in_ready = 1.
- Reset mid-operation:
  - The transaction is abandoned with no out_valid.
  - mem_req_valid drops immediately.
  - A later mem_resp_valid is ignored while in IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid, all request fields are captured.
  - Illegal size (in_size = 3 with XLEN = 32) goes straight to DONE with out_fault = 1 and no bus access.
  - Otherwise the FSM goes to REQ.
- REQ:
  - mem_req_* are driven from registers and held stable until mem_req_ready.
  - The cycle where mem_req_valid && mem_req_ready holds, the FSM moves to RESP.
  - mem_resp_valid is ignored in REQ.
- RESP:
  - The FSM waits for mem_resp_valid, for any number of cycles, then moves to DONE.
  - A load registers the extended data.
  - mem_resp_err = 1 gives out_fault = 1 and out_rdata = 0.
- DONE:
  - out_valid = 1, with data held stable until out_ready.
  - When out_ready is seen, the FSM returns to IDLE.
  - in_ready stays 0 in DONE; there is no same-cycle re-accept.
- Latency with zero-wait bus and out_ready = 1:
  - Cycle 0: accept. Cycle 1: request issued. Cycle 2: response. Cycle 3: out_valid.
  - Minimum 4 cycles between accepts.
- Strobe generation: wstrb = ((1 << (1 << size)) − 1) << addr[OFF_W−1:0], truncated to STRB_W.
- Store data: wdata = in_wdata << (8 · offset).
- Load extraction:
  - The raw beat is shifted right by 8 · offset.
  - The result is truncated to 8, 16, 32 or 64 bits.
  - It is then sign-extended, or zero-extended when in_unsigned = 1. Size D is passed through unchanged.
- Size D with XLEN = 64 and offset 0 is a full beat: wstrb = 8'hFF.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined:
  - Any access where addr mod (1 << size) ≠ 0 skips the bus.
  - The FSM goes IDLE → DONE with out_fault = 1 and out_rdata = 0.
- Undefined:
  - Misaligned accesses are issued as-is.
  - Strobe bits beyond STRB_W are dropped, so the access never crosses a beat; no fault is raised.

Decomposition:
- Package lsu_pkg holds:
  - lsu_size_e: B, H, W, D.
  - lsu_state_e: IDLE, REQ, RESP, DONE.
  - Width helper constants.
- Sub-module lsu_align (combinational) generates strobes and shifted write data for stores, and performs load shift and extension.
- lsu_mem_ctrl holds the FSM and registers only.

Test Plan:
- Word store, XLEN = 64: addr 0x8000_0004, size W, wdata 0x1122_3344 → mem_req_addr 0x8000_0000, wstrb 8'hF0, wdata 0x1122_3344_0000_0000; out_valid with out_rdata 0.
- Signed byte load: addr 0x8000_0003, beat 0x0000_0000_8000_0000 → out_rdata 0xFFFF_FFFF_FFFF_FF80. Same with in_unsigned = 1 → 0x80.
- Backpressure: mem_req_ready low for 5 cycles, response 3 cycles later, out_ready low for 2 cycles → request fields stable throughout, in_ready 0 until the out handshake, exactly one bus request.
- Bus error on a load: mem_resp_err = 1 → out_fault = 1, out_rdata = 0, FSM returns to IDLE.
- Misaligned halfword load at addr 0x...01:
  - With LSU_MISALIGN_TRAP_EN: fault and no mem_req_valid.
  - Without it: wstrb-equivalent lanes 1–2 are read and the extended result is returned.
- Reset asserted in RESP, response arriving after release → no out_valid; in_ready = 1 in the first cycle after release.
